// File: rtl/bus_source_encoder_if.sv
// Bus-source select interface between the control sequencer and the
// bus-driver encoder.
//   master : control-unit side; drives strobes/controls, observes status.
//   slave  : encoder side; consumes strobes, drives select and debug status.
interface bus_source_encoder_if #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 8
);
  logic [NUM_SRC-1:0] src_out_en;
  logic               hold;
  logic               err_clr;
  logic               util_clr;
  logic [SEL_W-1:0]   select_signal;
  logic               bus_valid;
  logic               conflict;
  logic               conflict_sticky;
  logic [CNT_W-1:0]   conflict_count;
  logic [CNT_W-1:0]   util_count;
  logic [SEL_W-1:0]   last_src;

  modport master (
    output src_out_en, hold, err_clr, util_clr,
    input  select_signal, bus_valid, conflict, conflict_sticky,
           conflict_count, util_count, last_src
  );

  modport slave (
    input  src_out_en, hold, err_clr, util_clr,
    output select_signal, bus_valid, conflict, conflict_sticky,
           conflict_count, util_count, last_src
  );
endinterface

// File: rtl/bus_source_encoder.sv
// Bus-source encoder: turns one-hot "out" strobes into the registered 5-bit
// select code of the 32-to-1 bus mux, resolving multi-driver cycles to the
// lowest index and counting them, plus a bus-utilisation counter.
// Ports:
//   clock   : rising-edge clock
//   clear_n : synchronous active-low reset
//   bus     : slave modport (strobes, hold, err_clr, util_clr in;
//             select_signal, bus_valid, conflict, conflict_sticky,
//             conflict_count, util_count, last_src out)
module bus_source_encoder #(
  parameter int NUM_SRC  = 24,
  parameter int SEL_W    = 5,
  parameter int IDLE_SEL = 31,
  parameter int CNT_W    = 8
) (
  input  logic                 clock,
  input  logic                 clear_n,
  bus_source_encoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(IDLE_SEL);

  logic [SEL_W-1:0] low_idx;
  logic             any_src;
  logic             multi_src;
  logic             new_conflict;
  logic             valid_next;

  logic [SEL_W-1:0] select_q;
  logic             valid_q;
  logic             conflict_q;
  logic             sticky_q;
  logic [CNT_W-1:0] conflict_cnt_q;
  logic [CNT_W-1:0] util_cnt_q;
  logic [SEL_W-1:0] last_q;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.src_out_en[i]) low_idx = SEL_W'(i);
    end
  end

  assign any_src      = |bus.src_out_en;
  // x & (x-1) clears the lowest set bit; anything left means >1 strobe.
  assign multi_src    = |(bus.src_out_en & (bus.src_out_en - NUM_SRC'(1)));
  assign new_conflict = ~bus.hold & multi_src;
  assign valid_next   = bus.hold ? valid_q : any_src;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      select_q       <= SEL_IDLE;
      valid_q        <= 1'b0;
      conflict_q     <= 1'b0;
      sticky_q       <= 1'b0;
      conflict_cnt_q <= '0;
      util_cnt_q     <= '0;
      last_q         <= '0;
    end else begin
      if (!bus.hold) begin
        if (any_src) begin
          select_q <= low_idx;
          valid_q  <= 1'b1;
          last_q   <= low_idx;
        end else begin
          select_q <= SEL_IDLE;
          valid_q  <= 1'b0;
        end
      end
      conflict_q <= new_conflict;

      // A fresh conflict beats err_clr; the count restarts at 1 in that case.
      if (new_conflict) begin
        sticky_q <= 1'b1;
        if (bus.err_clr)                  conflict_cnt_q <= CNT_W'(1);
        else if (conflict_cnt_q != CNT_MAX) conflict_cnt_q <= conflict_cnt_q + 1'b1;
      end else if (bus.err_clr) begin
        sticky_q       <= 1'b0;
        conflict_cnt_q <= '0;
      end

      // Counts on the post-update bus_valid, so a held valid keeps counting.
      if (valid_next) begin
        if (bus.util_clr)               util_cnt_q <= CNT_W'(1);
        else if (util_cnt_q != CNT_MAX) util_cnt_q <= util_cnt_q + 1'b1;
      end else if (bus.util_clr) begin
        util_cnt_q <= '0;
      end
    end
  end

  assign bus.select_signal   = select_q;
  assign bus.bus_valid       = valid_q;
  assign bus.conflict        = conflict_q;
  assign bus.conflict_sticky = sticky_q;
  assign bus.conflict_count  = conflict_cnt_q;
  assign bus.util_count      = util_cnt_q;
  assign bus.last_src        = last_q;

endmodule

// File: tb/tb_bus_source_encoder.sv
// Scoreboard bench for bus_source_encoder: a driver applies strobes and pushes
// the reference model's expected outputs; a monitor pops and compares after
// every clock edge.
module tb_bus_source_encoder;

  localparam int NUM_SRC = 24;
  localparam int SEL_W   = 5;
  localparam int CNT_W   = 8;

  logic clock;
  logic clear_n;

  bus_source_encoder_if #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) bif ();

  bus_source_encoder #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .IDLE_SEL(31), .CNT_W(CNT_W)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int sel;
    int valid;
    int conf;
    int sticky;
    int ccount;
    int ucount;
    int last;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;          // reference model state
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the behaviour rules stated in plain arithmetic.
  task automatic model_step(input logic [NUM_SRC-1:0] en, input bit h,
                            input bit ec, input bit uc, input bit cn);
    int n;
    int idx;
    bit new_conf;
    if (!cn) begin
      m.sel = 31; m.valid = 0; m.conf = 0; m.sticky = 0;
      m.ccount = 0; m.ucount = 0; m.last = 0;
      return;
    end
    new_conf = 0;
    if (!h) begin
      n = $countones(en);
      if (n == 0) begin
        m.sel = 31; m.valid = 0;
      end else begin
        idx = -1;
        for (int i = 0; i < NUM_SRC; i++)
          if (en[i] && idx < 0) idx = i;
        m.sel = idx; m.valid = 1; m.last = idx;
        new_conf = (n > 1);
      end
    end
    m.conf = new_conf ? 1 : 0;
    if (new_conf) begin
      m.sticky = 1;
      m.ccount = ec ? 1 : ((m.ccount + 1 > 255) ? 255 : m.ccount + 1);
    end else if (ec) begin
      m.sticky = 0; m.ccount = 0;
    end
    if (m.valid == 1)
      m.ucount = uc ? 1 : ((m.ucount + 1 > 255) ? 255 : m.ucount + 1);
    else if (uc)
      m.ucount = 0;
  endtask

  task automatic drive(input logic [NUM_SRC-1:0] en, input bit h = 0,
                       input bit ec = 0, input bit uc = 0, input bit cn = 1);
    @(negedge clock);
    bif.src_out_en = en;
    bif.hold       = h;
    bif.err_clr    = ec;
    bif.util_clr   = uc;
    clear_n        = cn;
    model_step(en, h, ec, uc, cn);
    exp_q.push_back(m);
  endtask

  // Sample just after the edge that the pending expectation belongs to.
  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  // Monitor: the DUT presents a new registered result after every edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("select_signal",   int'(bif.select_signal),   e.sel);
      check("bus_valid",       int'(bif.bus_valid),       e.valid);
      check("conflict",        int'(bif.conflict),        e.conf);
      check("conflict_sticky", int'(bif.conflict_sticky), e.sticky);
      check("conflict_count",  int'(bif.conflict_count),  e.ccount);
      check("util_count",      int'(bif.util_count),      e.ucount);
      check("last_src",        int'(bif.last_src),        e.last);
    end
  end

  initial begin
    logic [NUM_SRC-1:0] r;
    int wait_cyc;
    bif.src_out_en = '0;
    bif.hold = 0; bif.err_clr = 0; bif.util_clr = 0;
    clear_n = 0;
    m = '{31, 0, 0, 0, 0, 0, 0};

    // Reset with a strobe present.
    drive(24'h000010, 0, 0, 0, 0);
    drive(24'h000010, 0, 0, 0, 0);
    settle();
    check("reset_select", int'(bif.select_signal), 31);
    check("reset_valid",  int'(bif.bus_valid), 0);
    check("reset_last",   int'(bif.last_src), 0);

    // Single-source sweep.
    for (int i = 0; i < NUM_SRC; i++) drive(NUM_SRC'(1) << i);
    settle();
    check("sweep_util", int'(bif.util_count), 24);
    check("sweep_last", int'(bif.last_src), 23);

    // Conflict PCout + R2out, then idle.
    drive(24'h100004);
    settle();
    check("conf_select", int'(bif.select_signal), 2);
    check("conf_pulse",  int'(bif.conflict), 1);
    check("conf_count",  int'(bif.conflict_count), 1);
    drive(24'h000000);
    settle();
    check("idle_select", int'(bif.select_signal), 31);
    check("idle_last",   int'(bif.last_src), 2);
    check("idle_sticky", int'(bif.conflict_sticky), 1);

    // Hold over MDRout while conflicting strobes are present.
    drive(24'h000000, 0, 0, 1);
    drive(24'h200000);
    for (int i = 0; i < 3; i++) drive(24'h000003, 1);
    settle();
    check("hold_select", int'(bif.select_signal), 21);
    check("hold_util",   int'(bif.util_count), 4);
    check("hold_conf",   int'(bif.conflict), 0);

    // Saturation then err_clr collision.
    for (int i = 0; i < 300; i++) drive(24'h000003 | (NUM_SRC'(1) << (2 + (i % 20))));
    settle();
    check("sat_conflict", int'(bif.conflict_count), 255);
    check("sat_util",     int'(bif.util_count), 255);
    drive(24'h000c00, 0, 1);
    settle();
    check("clr_collide_count",  int'(bif.conflict_count), 1);
    check("clr_collide_sticky", int'(bif.conflict_sticky), 1);
    drive(24'h000000, 0, 1);
    settle();
    check("clr_count",  int'(bif.conflict_count), 0);
    check("clr_sticky", int'(bif.conflict_sticky), 0);

    // Reset during a hold on PCout.
    drive(24'h100000);
    drive(24'h000001, 1);
    drive(24'h000001, 1, 0, 0, 0);
    settle();
    check("rst_hold_select", int'(bif.select_signal), 31);
    check("rst_hold_valid",  int'(bif.bus_valid), 0);
    check("rst_hold_util",   int'(bif.util_count), 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 3)      r = '0;
      else if (kind < 7) r = NUM_SRC'(1) << $urandom_range(0, NUM_SRC - 1);
      else               r = NUM_SRC'($urandom);
      drive(r, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 39) != 0);
    end

    // Drain the scoreboard with a bounded wait.
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clock);
      wait_cyc++;
    end
    #3;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
